// File: rtl/hk_const_pkg.sv
// Shared types, defaults and helpers for the SHA-256 H/K constant store.
package hk_const_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DONE  = 1'b1
  } hk_state_e;

  localparam logic SEL_H = 1'b0;
  localparam logic SEL_K = 1'b1;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_H_WORDS  = 8;
  localparam int unsigned DEF_K_WORDS  = 64;
  localparam int unsigned DEF_ROM_AW   = 13;
  localparam int unsigned DEF_ROM_WAIT = 15;
  localparam int unsigned DEF_HA_W     = 3;
  localparam int unsigned DEF_KA_W     = 6;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/hk_rom_fetch.sv
// Walks the ROM image one word at a time, holding each address for
// ROM_WAIT extra cycles and strobing a write when the data is valid.
module hk_rom_fetch
  import hk_const_pkg::*;
#(
  parameter int unsigned N_WORDS  = DEF_H_WORDS + DEF_K_WORDS,
  parameter int unsigned ROM_AW   = DEF_ROM_AW,
  parameter int unsigned ROM_WAIT = DEF_ROM_WAIT,
  parameter int unsigned IDX_W    = clog2(N_WORDS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              restart_i,
  input  logic              run_i,
  output logic [ROM_AW-1:0] rom_a_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              wr_c,
  output logic              last_c
);

  localparam int unsigned      CNT_W    = clog2(ROM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ROM_WAIT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign wr_c    = run_i && (cnt_q == CNT_MAX);
  assign last_c  = wr_c && (idx_q == IDX_LAST);
  assign rom_a_o = ROM_AW'(idx_q);
  assign idx_o   = idx_q;

  // The index parks on the last word so ROM_A never leaves the image.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (restart_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (run_i) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (idx_q != IDX_LAST) idx_d = idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/hk_const_loader.sv
// SHA-256 H/K constant store: copies the image from a slow ROM after reset
// or LOAD, then serves single-word reads with a one-cycle req/ack.
module hk_const_loader
  import hk_const_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned H_WORDS  = DEF_H_WORDS,
  parameter int unsigned K_WORDS  = DEF_K_WORDS,
  parameter int unsigned ROM_AW   = DEF_ROM_AW,
  parameter int unsigned ROM_WAIT = DEF_ROM_WAIT,
  parameter int unsigned HA_W     = DEF_HA_W,
  parameter int unsigned KA_W     = DEF_KA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD,
  output logic [ROM_AW-1:0] ROM_A,
  input  logic [DATA_W-1:0] ROM_D,
  input  logic              SEL,
  input  logic [HA_W-1:0]   H_ADDR,
  input  logic [KA_W-1:0]   K_ADDR,
  input  logic              RD_REQ,
  output logic              RD_ACK,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RDY,
  output logic              BUSY,
  output logic              ERR
);

  localparam int unsigned N_WORDS = H_WORDS + K_WORDS;
  localparam int unsigned IDX_W   = clog2(N_WORDS);

  if (64'(N_WORDS) > (64'd1 << ROM_AW)) begin : g_bad_rom_aw
    $error("hk_const_loader: H_WORDS+K_WORDS does not fit in ROM_AW address bits");
  end
  if (HA_W < clog2(H_WORDS) || KA_W < clog2(K_WORDS)) begin : g_bad_addr_w
    $error("hk_const_loader: HA_W/KA_W too narrow for H_WORDS/K_WORDS");
  end

  hk_state_e         state_q;
  logic              rdy_q, busy_q, ack_q, err_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem_q [N_WORDS];

  logic              run_c, restart_c, wr_c, last_c;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx_c;
  logic              rd_oob_c;

  assign run_c     = (state_q == ST_FETCH);
  assign restart_c = (state_q == ST_DONE) && LOAD;

  hk_rom_fetch #(
    .N_WORDS  (N_WORDS),
    .ROM_AW   (ROM_AW),
    .ROM_WAIT (ROM_WAIT),
    .IDX_W    (IDX_W)
  ) u_fetch (
    .CLK       (CLK),
    .RST       (RST),
    .restart_i (restart_c),
    .run_i     (run_c),
    .rom_a_o   (ROM_A),
    .idx_o     (wr_idx),
    .wr_c      (wr_c),
    .last_c    (last_c)
  );

  // K words sit directly after the H words in the flat array.
  always_comb begin
    rd_oob_c = 1'b0;
    rd_idx_c = IDX_W'(H_ADDR);
    if (SEL == SEL_K) begin
      rd_oob_c = (32'(K_ADDR) >= K_WORDS);
      rd_idx_c = IDX_W'(H_WORDS) + IDX_W'(K_ADDR);
    end else begin
      rd_oob_c = (32'(H_ADDR) >= H_WORDS);
    end
  end

  // Storage is deliberately not reset; a reset only restarts the copy.
  always_ff @(posedge CLK) begin
    if (!RST && wr_c) mem_q[wr_idx] <= ROM_D;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FETCH;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (RD_REQ) err_q <= 1'b1;
          if (last_c) begin
            state_q <= ST_DONE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          // A read arriving with LOAD is dropped without an ack.
          if (LOAD) begin
            state_q <= ST_FETCH;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else if (RD_REQ) begin
            ack_q <= 1'b1;
            if (rd_oob_c) begin
              data_q <= '0;
              err_q  <= 1'b1;
            end else begin
              data_q <= mem_q[rd_idx_c];
            end
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign RDY     = rdy_q;
  assign BUSY    = busy_q;
  assign RD_ACK  = ack_q;
  assign RD_DATA = data_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_hk_const_loader.sv
// Bench for hk_const_loader: default build, ROM_WAIT=0 build and an
// H_WORDS=6 build, each fed by a wait-state-aware ROM model.
module tb_hk_const_loader;

  localparam int unsigned NW = 72;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sha [NW] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] img0 [NW];
  logic [31:0] img1 [NW];
  logic [31:0] img2 [NW];
  logic [31:0] exp0 [NW];

  logic        rst0, load0, sel0, req0, ack0, rdy0, busy0, err0;
  logic [2:0]  ha0;
  logic [5:0]  ka0;
  logic [12:0] roma0, last_a0;
  logic [31:0] romd0, data0;
  int          age0 = 0;

  logic        rst1, load1, sel1, req1, ack1, rdy1, busy1, err1;
  logic [2:0]  ha1;
  logic [5:0]  ka1;
  logic [12:0] roma1;
  logic [31:0] romd1, data1;

  logic        rst2, load2, sel2, req2, ack2, rdy2, busy2, err2;
  logic [2:0]  ha2;
  logic [5:0]  ka2;
  logic [12:0] roma2, last_a2;
  logic [31:0] romd2, data2;
  int          age2 = 0;

  // ROM model: data is garbage until the address has been stable long enough.
  always @(negedge clk) begin
    if (roma0 !== last_a0) age0 <= 0; else age0 <= age0 + 1;
    last_a0 <= roma0;
    if (roma2 !== last_a2) age2 <= 0; else age2 <= age2 + 1;
    last_a2 <= roma2;
  end
  assign romd0 = (age0 >= 15 && roma0 < 13'd72) ? img0[roma0[6:0]] : 32'hdeadbeef;
  assign romd1 = (roma1 < 13'd72) ? img1[roma1[6:0]] : 32'hdeadbeef;
  assign romd2 = (age2 >= 1 && roma2 < 13'd70) ? img2[roma2[6:0]] : 32'hdeadbeef;

  hk_const_loader u_dut0 (
    .CLK(clk), .RST(rst0), .LOAD(load0), .ROM_A(roma0), .ROM_D(romd0),
    .SEL(sel0), .H_ADDR(ha0), .K_ADDR(ka0), .RD_REQ(req0), .RD_ACK(ack0),
    .RD_DATA(data0), .RDY(rdy0), .BUSY(busy0), .ERR(err0)
  );

  hk_const_loader #(.ROM_WAIT(0)) u_dut1 (
    .CLK(clk), .RST(rst1), .LOAD(load1), .ROM_A(roma1), .ROM_D(romd1),
    .SEL(sel1), .H_ADDR(ha1), .K_ADDR(ka1), .RD_REQ(req1), .RD_ACK(ack1),
    .RD_DATA(data1), .RDY(rdy1), .BUSY(busy1), .ERR(err1)
  );

  hk_const_loader #(.H_WORDS(6), .ROM_WAIT(1)) u_dut2 (
    .CLK(clk), .RST(rst2), .LOAD(load2), .ROM_A(roma2), .ROM_D(romd2),
    .SEL(sel2), .H_ADDR(ha2), .K_ADDR(ka2), .RD_REQ(req2), .RD_ACK(ack2),
    .RD_DATA(data2), .RDY(rdy2), .BUSY(busy2), .ERR(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference read: {out_of_range, data} from the stored image.
  function automatic logic [32:0] ref_read(input logic [31:0] st [NW], input int hw,
                                           input int kw, input logic sel, input int h,
                                           input int k);
    if (!sel) return (h < hw) ? {1'b0, st[h]} : {1'b1, 32'h0};
    return (k < kw) ? {1'b0, st[hw + k]} : {1'b1, 32'h0};
  endfunction

  logic [32:0] e;
  logic [31:0] hold0;
  int          n, rise, busy_viol, a_viol;

  initial begin
    rst0 = 1; load0 = 0; sel0 = 0; ha0 = 0; ka0 = 0; req0 = 0;
    rst1 = 1; load1 = 0; sel1 = 0; ha1 = 0; ka1 = 0; req1 = 0;
    rst2 = 1; load2 = 0; sel2 = 0; ha2 = 0; ka2 = 0; req2 = 0;
    for (int i = 0; i < int'(NW); i++) begin
      img0[i] = sha[i];
      img1[i] = sha[i];
      img2[i] = $urandom;
    end
    repeat (3) tick();
    chk("rst_rdy", 32'(rdy0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_ack", 32'(ack0), 32'd0);
    chk("rst_data", data0, 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_roma", 32'(roma0), 32'd0);

    // Run the first copy up to word 30, then pulse reset.
    rst0 = 0;
    n = 0;
    while (roma0 != 13'd30 && n < 2000) begin
      tick();
      n++;
    end
    chk("reach_idx30", 32'(roma0), 32'd30);
    rst0 = 1;
    tick();
    rst0 = 0;
    chk("midrst_busy", 32'(busy0), 32'd1);
    chk("midrst_roma", 32'(roma0), 32'd0);
    chk("midrst_rdy", 32'(rdy0), 32'd0);

    // Restarted copy, with a premature read at cycle 10.
    rise = 0; busy_viol = 0;
    for (int k = 1; k <= 2000 && rise == 0; k++) begin
      tick();
      if (k == 10) begin
        req0 = 1'b0;
        chk("early_req_ack", 32'(ack0), 32'd0);
        chk("early_req_err", 32'(err0), 32'd1);
        chk("early_req_data", data0, 32'd0);
      end
      if (k == 9) req0 = 1'b1;
      if (rdy0) rise = k;
      else if (!busy0) busy_viol++;
    end
    chk("rdy_latency", 32'(rise), 32'd1152);
    chk("busy_during_copy", 32'(busy_viol), 32'd0);
    chk("done_busy", 32'(busy0), 32'd0);
    chk("done_err_sticky", 32'(err0), 32'd1);
    chk("done_roma_last", 32'(roma0), 32'd71);
    for (int i = 0; i < int'(NW); i++) exp0[i] = img0[i];

    sel0 = 0; ha0 = 0; req0 = 1;
    tick();
    chk("h0_ack", 32'(ack0), 32'd1);
    chk("h0_data", data0, 32'h6a09e667);
    sel0 = 1; ka0 = 6'd63;
    tick();
    chk("k63_ack", 32'(ack0), 32'd1);
    chk("k63_data", data0, 32'hc67178f2);

    // Eight back-to-back reads alternating H and K.
    for (int i = 0; i < 8; i++) begin
      sel0 = i[0]; ha0 = 3'($urandom); ka0 = 6'($urandom);
      e = ref_read(exp0, 8, 64, sel0, int'(ha0), int'(ka0));
      tick();
      chk("b2b_ack", 32'(ack0), 32'd1);
      chk("b2b_data", data0, e[31:0]);
      hold0 = e[31:0];
    end
    req0 = 0;
    tick();
    chk("idle_ack", 32'(ack0), 32'd0);
    chk("idle_hold", data0, hold0);

    // Random sparse reads; data holds between acknowledged reads.
    for (int i = 0; i < 40; i++) begin
      req0 = 1'($urandom); sel0 = 1'($urandom); ha0 = 3'($urandom); ka0 = 6'($urandom);
      e = ref_read(exp0, 8, 64, sel0, int'(ha0), int'(ka0));
      tick();
      if (req0) begin
        chk("rnd_ack", 32'(ack0), 32'd1);
        chk("rnd_data", data0, e[31:0]);
        hold0 = e[31:0];
      end else begin
        chk("rnd_noack", 32'(ack0), 32'd0);
        chk("rnd_hold", data0, hold0);
      end
    end

    // New ROM image, reload with a read in the same cycle.
    for (int i = 0; i < int'(NW); i++) img0[i] = 32'(i) ^ 32'ha5a5a5a5;
    load0 = 1; req0 = 1; sel0 = 0; ha0 = 3'd3;
    tick();
    load0 = 0; req0 = 0;
    chk("load_rdy", 32'(rdy0), 32'd0);
    chk("load_busy", 32'(busy0), 32'd1);
    chk("load_drop_ack", 32'(ack0), 32'd0);
    chk("load_hold", data0, hold0);
    chk("load_roma", 32'(roma0), 32'd0);
    rise = 0; a_viol = 0;
    for (int k = 1; k <= 2000 && rise == 0; k++) begin
      tick();
      if (k == 101) load0 = 1'b0;
      if (k == 100) load0 = 1'b1;
      if (roma0 >= 13'd72) a_viol++;
      if (rdy0) rise = k;
    end
    chk("reload_latency", 32'(rise), 32'd1152);
    chk("reload_addr_range", 32'(a_viol), 32'd0);
    for (int i = 0; i < int'(NW); i++) exp0[i] = img0[i];
    sel0 = 0; ha0 = 3'd7; req0 = 1;
    tick();
    chk("reload_h7", data0, 32'ha5a5a5a2);
    for (int i = 0; i < 20; i++) begin
      sel0 = 1'($urandom); ha0 = 3'($urandom); ka0 = 6'($urandom);
      e = ref_read(exp0, 8, 64, sel0, int'(ha0), int'(ka0));
      tick();
      chk("reload_rnd", data0, e[31:0]);
    end
    req0 = 0;
    chk("reload_err_sticky", 32'(err0), 32'd1);
    rst0 = 1;
    tick();
    chk("rst_clears_err", 32'(err0), 32'd0);

    // ROM_WAIT=0 build: full image in 72 cycles.
    rst1 = 0;
    rise = 0;
    for (int k = 1; k <= 500 && rise == 0; k++) begin
      tick();
      if (rdy1) rise = k;
    end
    chk("w0_latency", 32'(rise), 32'd72);
    req1 = 1;
    for (int i = 0; i < int'(NW); i++) begin
      sel1 = (i >= 8); ha1 = 3'(i); ka1 = 6'(i - 8);
      tick();
      chk("w0_word", data1, sha[i]);
    end
    req1 = 0;

    // H_WORDS=6 build with a random image, then an out-of-range H read.
    rst2 = 0;
    rise = 0;
    for (int k = 1; k <= 500 && rise == 0; k++) begin
      tick();
      if (rdy2) rise = k;
    end
    chk("h6_latency", 32'(rise), 32'd140);
    req2 = 1;
    for (int i = 0; i < 16; i++) begin
      sel2 = (i >= 6); ha2 = 3'(i); ka2 = 6'($urandom);
      e = ref_read(img2, 6, 64, sel2, int'(ha2), int'(ka2));
      tick();
      chk("h6_data", data2, e[31:0]);
    end
    chk("h6_err_clean", 32'(err2), 32'd0);
    sel2 = 0; ha2 = 3'd7;
    tick();
    req2 = 0;
    chk("h6_oob_ack", 32'(ack2), 32'd1);
    chk("h6_oob_data", data2, 32'd0);
    chk("h6_oob_err", 32'(err2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
